// File: rtl/barrel_rot_arbiter_if.sv
// Request/response and rotator-control bundle for barrel_rot_arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/consumer/rotator side.
interface barrel_rot_arbiter_if #(
   parameter int W    = 8,
   parameter int SW   = 3,
   parameter int REPW = 3
);
   logic            req0_valid;
   logic            req0_ready;
   logic [W-1:0]    req0_data;
   logic [SW-1:0]   req0_sel;
   logic [REPW-1:0] req0_rep;

   logic            req1_valid;
   logic            req1_ready;
   logic [W-1:0]    req1_data;
   logic [SW-1:0]   req1_sel;
   logic [REPW-1:0] req1_rep;

   logic            resp_valid;
   logic            resp_ready;
   logic [W-1:0]    resp_data;
   logic            resp_id;

   logic            bar_load;
   logic [SW-1:0]   bar_sel;
   logic [W-1:0]    bar_din;
   logic [W-1:0]    bar_dout;

   modport slave (
      input  req0_valid, req0_data, req0_sel, req0_rep,
      output req0_ready,
      input  req1_valid, req1_data, req1_sel, req1_rep,
      output req1_ready,
      output resp_valid, resp_data, resp_id,
      input  resp_ready,
      output bar_load, bar_sel, bar_din,
      input  bar_dout
   );

   modport master (
      output req0_valid, req0_data, req0_sel, req0_rep,
      input  req0_ready,
      output req1_valid, req1_data, req1_sel, req1_rep,
      input  req1_ready,
      input  resp_valid, resp_data, resp_id,
      output resp_ready,
      input  bar_load, bar_sel, bar_din,
      output bar_dout
   );
endinterface

// File: rtl/barrel_rot_arbiter.sv
// Round-robin arbiter that sequences a shared registered barrel rotator through
// LOAD plus rep-1 SHIFT steps. It returns the rotator output with the winner's ID.
module barrel_rot_arbiter #(
   parameter int W    = 8,
   parameter int SW   = 3,
   parameter int REPW = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   barrel_rot_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESP} state_t;

   state_t          state;
   state_t          state_next;
   logic [W-1:0]    data_q;
   logic [SW-1:0]   sel_q;
   logic [REPW-1:0] rep_q;
   logic [REPW-1:0] cnt_q;
   logic            id_q;
   logic            last_q;
   logic            grant0;
   logic            grant1;
   logic            accept;

   // last_q=1 means requester 1 won most recently, so requester 0 wins the next tie.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE && !reset) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant0 = last_q;
            grant1 = !last_q;
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
         end
      end
   end

   assign accept         = grant0 | grant1;
   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         last_q <= 1'b1;
         id_q   <= 1'b0;
         data_q <= '0;
         sel_q  <= '0;
         rep_q  <= '0;
         cnt_q  <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            data_q <= grant1 ? bus.req1_data : bus.req0_data;
            sel_q  <= grant1 ? bus.req1_sel  : bus.req0_sel;
            if (grant1)
               rep_q <= (bus.req1_rep == '0) ? REPW'(1) : bus.req1_rep;
            else
               rep_q <= (bus.req0_rep == '0) ? REPW'(1) : bus.req0_rep;
            id_q   <= grant1;
            last_q <= grant1;
         end
         if (state == LOAD)
            cnt_q <= rep_q - REPW'(1);
         else if (state == SHIFT)
            cnt_q <= cnt_q - REPW'(1);
      end
   end

   // The counter holds the remaining SHIFT steps, including the current one.
   always_comb begin
      state_next     = state;
      bus.bar_load   = 1'b0;
      bus.bar_sel    = '0;
      bus.bar_din    = '0;
      bus.resp_valid = 1'b0;
      bus.resp_data  = '0;
      bus.resp_id    = 1'b0;
      case (state)
         IDLE: begin
            if (accept)
               state_next = LOAD;
         end
         LOAD: begin
            bus.bar_load = 1'b1;
            bus.bar_sel  = sel_q;
            bus.bar_din  = data_q;
            state_next   = (rep_q <= REPW'(1)) ? RESP : SHIFT;
         end
         SHIFT: begin
            bus.bar_sel = sel_q;
            if (cnt_q <= REPW'(1))
               state_next = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = bus.bar_dout;
            bus.resp_id    = id_q;
            if (bus.resp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_barrel_rot_arbiter.sv
// Bench for barrel_rot_arbiter: a behavioural rotator, a scoreboard monitor,
// a vector table and hand sequences for stall, abort and tie alternation.
module tb_barrel_rot_arbiter;
   localparam int W    = 8;
   localparam int SW   = 3;
   localparam int REPW = 3;

   typedef struct {
      logic       id;
      logic [7:0] data;
      logic [2:0] sel;
      logic [2:0] rep;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      logic       id;
      logic [7:0] data;
      int         lat;
      int         acc_cycle;
   } sb_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   cycle  = 0;
   bit   busy   = 1'b0;
   logic prev_valid = 1'b0;
   sb_t  sbq[$];
   vec_t vecs[7];

   always #5 clk = ~clk;

   barrel_rot_arbiter_if #(.W(W), .SW(SW), .REPW(REPW)) bus();

   barrel_rot_arbiter #(.W(W), .SW(SW), .REPW(REPW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [7:0] rotr(input logic [7:0] d, input int n);
      logic [15:0] t;
      t = {d, d} >> (n % 8);
      return t[7:0];
   endfunction

   // Registered rotator model driven by the arbiter's bar_* outputs.
   always @(posedge clk) begin
      if (reset)
         bus.bar_dout <= '0;
      else if (bus.bar_load)
         bus.bar_dout <= rotr(bus.bar_din, int'(bus.bar_sel));
      else
         bus.bar_dout <= rotr(bus.bar_dout, int'(bus.bar_sel));
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   function automatic sb_t makeEntry(input logic id, input logic [7:0] d, input logic [2:0] s,
                                     input logic [2:0] r, input int c);
      sb_t e;
      int  reps;
      reps        = (r == 3'd0) ? 1 : int'(r);
      e.id        = id;
      e.data      = rotr(d, (int'(s) * reps) % W);
      e.lat       = reps + 1;
      e.acc_cycle = c;
      return e;
   endfunction

   // Monitor: pushes on accept, checks latency on resp_valid rise, pops on handshake.
   always @(negedge clk) begin
      cycle++;
      if (reset) begin
         sbq.delete();
         busy       = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (bus.req0_ready || bus.req1_ready) begin
            checkOutput("ready_onehot", 32'(bus.req0_ready && bus.req1_ready), 0);
            checkOutput("ready_while_busy", 32'(busy), 0);
         end
         if (bus.req0_ready && bus.req0_valid) begin
            sbq.push_back(makeEntry(1'b0, bus.req0_data, bus.req0_sel, bus.req0_rep, cycle));
            busy = 1'b1;
         end else if (bus.req1_ready && bus.req1_valid) begin
            sbq.push_back(makeEntry(1'b1, bus.req1_data, bus.req1_sel, bus.req1_rep, cycle));
            busy = 1'b1;
         end
         if (bus.resp_valid && !prev_valid) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("[TB] FAIL resp_unexpected: got resp_valid=1 expected no response");
            end else if (cycle - sbq[0].acc_cycle != sbq[0].lat) begin
               errors++;
               $display("[TB] FAIL latency: got %0d expected %0d", cycle - sbq[0].acc_cycle, sbq[0].lat);
            end
         end
         if (bus.resp_valid && bus.resp_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL sb_empty: got handshake expected none");
            end else begin
               sb_t e;
               e = sbq.pop_front();
               checkOutput("sb_data", 32'(bus.resp_data), 32'(e.data));
               checkOutput("sb_id", 32'(bus.resp_id), 32'(e.id));
            end
            busy = 1'b0;
         end
         prev_valid = bus.resp_valid;
      end
   end

   task automatic applyStimulus(input logic id, input logic [7:0] d, input logic [2:0] s, input logic [2:0] r);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_sel = s; bus.req1_rep = r;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_sel = s; bus.req0_rep = r;
      end
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if ((id && bus.req1_ready) || (!id && bus.req0_ready))
            ok = 1'b1;
      end
      @(posedge clk); #1;
      if (id) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
      checkOutput("accept_timeout", 32'(ok), 1);
   endtask

   task automatic waitResp(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.resp_valid)
            seen = 1'b1;
      end
      checkOutput("resp_timeout", 32'(seen), 1);
   endtask

   initial begin
      bit seen;
      vecs[0] = '{1'b0, 8'hB4, 3'd3, 3'd1, 8'h96};
      vecs[1] = '{1'b1, 8'h01, 3'd3, 3'd3, 8'h80};
      vecs[2] = '{1'b1, 8'h01, 3'd3, 3'd0, 8'h20};
      vecs[3] = '{1'b0, 8'hA5, 3'd1, 3'd4, 8'h5A};
      vecs[4] = '{1'b1, 8'h81, 3'd7, 3'd2, 8'h06};
      vecs[5] = '{1'b0, 8'hF0, 3'd0, 3'd5, 8'hF0};
      vecs[6] = '{1'b1, 8'hC3, 3'd5, 3'd7, 8'h78};

      // Reset with both requesters valid: nothing may be granted.
      reset = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_data = 8'h11; bus.req0_sel = 3'd1; bus.req0_rep = 3'd1;
      bus.req1_valid = 1'b1; bus.req1_data = 8'h22; bus.req1_sel = 3'd1; bus.req1_rep = 3'd1;
      bus.resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req0_ready", 32'(bus.req0_ready), 0);
      checkOutput("rst_req1_ready", 32'(bus.req1_ready), 0);
      checkOutput("rst_resp_valid", 32'(bus.resp_valid), 0);
      checkOutput("rst_resp_id", 32'(bus.resp_id), 0);
      checkOutput("rst_bar_load", 32'(bus.bar_load), 0);
      checkOutput("rst_bar_sel", 32'(bus.bar_sel), 0);
      checkOutput("rst_bar_din", 32'(bus.bar_din), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;

      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].id, vecs[v].data, vecs[v].sel, vecs[v].rep);
         waitResp(seen);
         if (seen) begin
            checkOutput("vec_data", 32'(bus.resp_data), 32'(vecs[v].exp));
            checkOutput("vec_id", 32'(bus.resp_id), 32'(vecs[v].id));
         end
         @(posedge clk); #1;
      end

      // Stalled response: must hold, keep the rotator idle and block new accepts.
      bus.resp_ready = 1'b0;
      applyStimulus(1'b0, 8'hB4, 3'd3, 3'd1);
      waitResp(seen);
      @(posedge clk); #1;
      bus.req1_valid = 1'b1; bus.req1_data = 8'h55; bus.req1_sel = 3'd1; bus.req1_rep = 3'd1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("stall_valid", 32'(bus.resp_valid), 1);
         checkOutput("stall_data", 32'(bus.resp_data), 32'h96);
         checkOutput("stall_id", 32'(bus.resp_id), 0);
         checkOutput("stall_bar_sel", 32'(bus.bar_sel), 0);
         checkOutput("stall_req1_ready", 32'(bus.req1_ready), 0);
      end
      @(posedge clk); #1;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("stall_release_valid", 32'(bus.resp_valid), 1);
      @(negedge clk);
      checkOutput("resume_req1_ready", 32'(bus.req1_ready), 1);
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      waitResp(seen);
      if (seen) begin
         checkOutput("resume_data", 32'(bus.resp_data), 32'hAA);
         checkOutput("resume_id", 32'(bus.resp_id), 1);
      end
      @(posedge clk); #1;

      // Abort a rep=5 command in the middle of its SHIFT phase.
      applyStimulus(1'b0, 8'h5A, 3'd1, 3'd5);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_resp_valid", 32'(bus.resp_valid), 0);
      checkOutput("abort_bar_load", 32'(bus.bar_load), 0);
      checkOutput("abort_bar_sel", 32'(bus.bar_sel), 0);
      checkOutput("abort_bar_din", 32'(bus.bar_din), 0);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         checkOutput("abort_no_resp", 32'(bus.resp_valid), 0);
      end

      // Both requesters valid continuously: grants alternate, starting with req0.
      @(posedge clk); #1;
      bus.req0_valid = 1'b1; bus.req0_data = 8'h12; bus.req0_sel = 3'd1; bus.req0_rep = 3'd2;
      bus.req1_valid = 1'b1; bus.req1_data = 8'h3C; bus.req1_sel = 3'd2; bus.req1_rep = 3'd1;
      for (int k = 0; k < 6; k++) begin
         waitResp(seen);
         if (seen) begin
            checkOutput("tie_id", 32'(bus.resp_id), 32'(k % 2));
            checkOutput("tie_data", 32'(bus.resp_data), (k % 2 == 0) ? 32'h84 : 32'h0F);
         end
      end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("sb_drained", 32'(sbq.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
